// File: rtl/router_pkg.sv
// Shared types and constants for the router output channel.
//   FLIT_W  : flit width (all-zero flit means "no data")
//   NUM_VC  : number of virtual channels per output port
//   vc_id_t : VC identifier, VC_EVEN drains in phase 0, VC_ODD in phase 1
//   flit_t  : one flit
package router_pkg;
  localparam int FLIT_W = 64;
  localparam int NUM_VC = 2;

  typedef enum logic {
    VC_EVEN = 1'b0,
    VC_ODD  = 1'b1
  } vc_id_t;

  typedef logic [FLIT_W-1:0] flit_t;
endpackage

// File: rtl/router_vc_fifo.sv
// Single virtual-channel FIFO with a combinational head output.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears pointers/count)
//   push, pop  : enqueue din / dequeue head; ignored when full / empty
//   din, dout  : write data / current head (valid only when !empty)
//   empty, full: occupancy flags derived from the registered count
module router_vc_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_push;
  logic              w_pop;

  assign empty  = (r_count == (PTR_W+1)'(0));
  assign full   = (r_count == (PTR_W+1)'(DEPTH));
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr];

  // Pointer and count update; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= (PTR_W+1)'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= din;
    end
  end
endmodule

// File: rtl/router_output_channel.sv
// Egress stage of a mesh router port: two VC FIFOs feeding a registered
// send/data link, with VC selection by the network-wide polarity bit.
// Optional build macro: ROUTER_OUT_STATS_EN adds tx_count / drop_count.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   polarity            : 0 drains VC0, 1 drains VC1
//   wr_en, wr_vc        : crossbar write strobe and target VC
//   data_in             : incoming flit (all-zero flit is ignored)
//   ready_in            : downstream can take a flit
//   vc_full             : per-VC full flags (back-pressure to crossbar)
//   tx_count            : (stats) pop counter, wraps
//   drop_count          : (stats) rejected non-zero writes, saturates
//   send, data_out      : registered link output; data_out is zero when !send
module router_output_channel
  import router_pkg::*;
#(
  parameter int DATA_W = FLIT_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              wr_en,
  input  logic              wr_vc,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ready_in,
  output logic [1:0]        vc_full,
`ifdef ROUTER_OUT_STATS_EN
  output logic [15:0]       tx_count,
  output logic [15:0]       drop_count,
`endif
  output logic              send,
  output logic [DATA_W-1:0] data_out
);
  vc_id_t            w_wr_vc;
  vc_id_t            w_cur;
  logic              w_is_data;
  logic              w_accept;
  logic [NUM_VC-1:0] w_push;
  logic [NUM_VC-1:0] w_pop;
  logic [NUM_VC-1:0] w_empty;
  logic [NUM_VC-1:0] w_full;
  logic [DATA_W-1:0] w_head [NUM_VC];
  logic              r_send;
  logic [DATA_W-1:0] r_data_out;

  assign w_wr_vc   = vc_id_t'(wr_vc);
  assign w_cur     = vc_id_t'(polarity);
  assign w_is_data = (data_in != {DATA_W{1'b0}});
  // Full check ignores a same-cycle pop, so a full VC always rejects.
  assign w_accept  = wr_en && w_is_data && !w_full[w_wr_vc];
  assign vc_full   = w_full;
  assign send      = r_send;
  assign data_out  = r_data_out;

  // Route accepted writes to one VC and pop only the phase-active VC.
  always_comb begin
    w_push = {NUM_VC{1'b0}};
    w_pop  = {NUM_VC{1'b0}};
    if (w_accept) begin
      w_push[w_wr_vc] = 1'b1;
    end else begin
      w_push = {NUM_VC{1'b0}};
    end
    if (!w_empty[w_cur] && ready_in) begin
      w_pop[w_cur] = 1'b1;
    end else begin
      w_pop = {NUM_VC{1'b0}};
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    router_vc_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push[g]),
      .pop   (w_pop[g]),
      .din   (data_in),
      .dout  (w_head[g]),
      .empty (w_empty[g]),
      .full  (w_full[g])
    );
  end

  // Registered link output: head of the popped VC, or zero when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_send     <= 1'b0;
      r_data_out <= {DATA_W{1'b0}};
    end else if (w_pop != {NUM_VC{1'b0}}) begin
      r_send     <= 1'b1;
      r_data_out <= w_head[w_cur];
    end else begin
      r_send     <= 1'b0;
      r_data_out <= {DATA_W{1'b0}};
    end
  end

`ifdef ROUTER_OUT_STATS_EN
  logic        w_reject;
  logic [15:0] r_tx_count;
  logic [15:0] r_drop_count;

  assign w_reject   = wr_en && w_is_data && w_full[w_wr_vc];
  assign tx_count   = r_tx_count;
  assign drop_count = r_drop_count;

  // Statistics: tx wraps on every pop, drop saturates on full-VC rejects.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_count   <= 16'h0000;
      r_drop_count <= 16'h0000;
    end else begin
      if (w_pop != {NUM_VC{1'b0}}) begin
        r_tx_count <= r_tx_count + 16'h0001;
      end
      if (w_reject && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'h0001;
      end
    end
  end
`endif
endmodule

// File: tb/tb_router_output_channel.sv
// Self-checking bench for router_output_channel: per-scenario tasks with a
// per-VC scoreboard queue filled when writes are driven and drained on send.
module tb_router_output_channel;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        polarity = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_vc = 1'b0;
  logic [63:0] data_in = 64'h0;
  logic        ready_in = 1'b0;
  logic [1:0]  vc_full;
  logic        send;
  logic [63:0] data_out;
`ifdef ROUTER_OUT_STATS_EN
  logic [15:0] tx_count;
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int failures = 0;
  int tx_model = 0;
  int drop_model = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  router_output_channel dut (
    .clk        (clk),
    .reset      (reset),
    .polarity   (polarity),
    .wr_en      (wr_en),
    .wr_vc      (wr_vc),
    .data_in    (data_in),
    .ready_in   (ready_in),
    .vc_full    (vc_full),
`ifdef ROUTER_OUT_STATS_EN
    .tx_count   (tx_count),
    .drop_count (drop_count),
`endif
    .send       (send),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one write and record what the channel should store or drop.
  task automatic drive_write(input logic vc, input logic [63:0] d);
    wr_en = 1'b1;
    wr_vc = vc;
    data_in = d;
    if (d != 64'h0) begin
      if (vc == 1'b0) begin
        if (q0.size() < 4) q0.push_back(d); else drop_model++;
      end else begin
        if (q1.size() < 4) q1.push_back(d); else drop_model++;
      end
    end
  endtask

  // Pull the expected head of a VC from the scoreboard.
  task automatic sb_pop(input logic vc, output logic [63:0] exp, output bit none);
    none = 1'b0;
    exp = 64'h0;
    if (vc == 1'b0) begin
      if (q0.size() == 0) none = 1'b1; else exp = q0.pop_front();
    end else begin
      if (q1.size() == 0) none = 1'b1; else exp = q1.pop_front();
    end
    if (!none) tx_model++;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b1; wr_vc = 1'b0; data_in = 64'hDEAD; ready_in = 1'b1;
    repeat (2) cycle();
    checks++;
    if ({send, data_out, vc_full} !== 67'h0)
      begin failures++; $display("FAIL reset_state: send=%b data=%h full=%b want 0/0/00", send, data_out, vc_full); end
    reset = 1'b0; wr_en = 1'b0; data_in = 64'h0;
    q0.delete(); q1.delete(); tx_model = 0; drop_model = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if ({send, data_out, vc_full} !== 67'h0)
        begin failures++; $display("FAIL idle[%0d]: send=%b data=%h full=%b want 0/0/00", i, send, data_out, vc_full); end
    end
  endtask

  task automatic test_single_vc0();
    logic [63:0] exp; bit none;
    polarity = 1'b0; ready_in = 1'b1;
    drive_write(1'b0, 64'hA1);
    cycle();
    wr_en = 1'b0; data_in = 64'h0;
    checks++;
    if (send !== 1'b0) begin failures++; $display("FAIL vc0_latency: send=%b want 0", send); end
    cycle();
    sb_pop(1'b0, exp, none);
    checks++;
    if (none || send !== 1'b1 || data_out !== exp)
      begin failures++; $display("FAIL vc0_send: send=%b data=%h want 1/%h", send, data_out, exp); end
    cycle();
    checks++;
    if (send !== 1'b0 || data_out !== 64'h0)
      begin failures++; $display("FAIL vc0_drop_send: send=%b data=%h want 0/0", send, data_out); end
  endtask

  task automatic test_vc1_polarity();
    logic [63:0] exp; bit none;
    polarity = 1'b0; ready_in = 1'b1;
    drive_write(1'b1, 64'hB2);
    cycle();
    wr_en = 1'b0; data_in = 64'h0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (send !== 1'b0) begin failures++; $display("FAIL vc1_wrong_phase[%0d]: send=%b want 0", i, send); end
      cycle();
    end
    polarity = 1'b1;
    cycle();
    sb_pop(1'b1, exp, none);
    checks++;
    if (none || send !== 1'b1 || data_out !== exp)
      begin failures++; $display("FAIL vc1_send: send=%b data=%h want 1/%h", send, data_out, exp); end
    polarity = 1'b0;
    cycle();
    checks++;
    if (send !== 1'b0) begin failures++; $display("FAIL vc1_after: send=%b want 0", send); end
  endtask

  task automatic test_full_drop();
    logic [63:0] exp; bit none;
    ready_in = 1'b0; polarity = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive_write(1'b0, 64'(i));
      cycle();
    end
    drive_write(1'b0, 64'h5);
    checks++;
    if (vc_full !== 2'b01 || send !== 1'b0)
      begin failures++; $display("FAIL full_flag: full=%b send=%b want 01/0", vc_full, send); end
    cycle();
    wr_en = 1'b0; data_in = 64'h0;
    checks++;
    if (vc_full !== 2'b01) begin failures++; $display("FAIL full_hold: full=%b want 01", vc_full); end
`ifdef ROUTER_OUT_STATS_EN
    checks++;
    if (drop_count !== 16'(drop_model))
      begin failures++; $display("FAIL drop_count: got %0d want %0d", drop_count, drop_model); end
`endif
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      sb_pop(1'b0, exp, none);
      checks++;
      if (none || send !== 1'b1 || data_out !== exp)
        begin failures++; $display("FAIL drain[%0d]: send=%b data=%h want 1/%h", i, send, data_out, exp); end
    end
    cycle();
    checks++;
    if (send !== 1'b0 || vc_full !== 2'b00)
      begin failures++; $display("FAIL drain_end: send=%b full=%b want 0/00", send, vc_full); end
  endtask

  task automatic test_full_pop_write();
    logic [63:0] exp; bit none;
    ready_in = 1'b0; polarity = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_write(1'b0, 64'h11 + 64'(i));
      cycle();
    end
    ready_in = 1'b1;
    drive_write(1'b0, 64'h9);
    cycle();
    wr_en = 1'b0; data_in = 64'h0;
    sb_pop(1'b0, exp, none);
    checks++;
    if (none || send !== 1'b1 || data_out !== exp || vc_full !== 2'b00)
      begin failures++; $display("FAIL pop_write: send=%b data=%h full=%b want 1/%h/00", send, data_out, vc_full, exp); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      sb_pop(1'b0, exp, none);
      checks++;
      if (none || send !== 1'b1 || data_out !== exp)
        begin failures++; $display("FAIL pop_write_drain[%0d]: send=%b data=%h want 1/%h", i, send, data_out, exp); end
    end
    cycle();
    checks++;
    if (send !== 1'b0 || data_out !== 64'h0)
      begin failures++; $display("FAIL pop_write_reject: send=%b data=%h want 0/0", send, data_out); end
`ifdef ROUTER_OUT_STATS_EN
    checks++;
    if (drop_count !== 16'(drop_model))
      begin failures++; $display("FAIL drop_count2: got %0d want %0d", drop_count, drop_model); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp; logic [63:0] d; bit none; bit exp_send; logic vc;
    for (int n = 0; n < 316; n++) begin
      if (n < 300) begin
        polarity = 1'($urandom_range(0, 1));
        ready_in = ($urandom_range(0, 3) != 0);
      end else begin
        polarity = 1'(n % 2);
        ready_in = 1'b1;
      end
      exp_send = ready_in && ((polarity ? q1.size() : q0.size()) > 0);
      if (n < 300 && $urandom_range(0, 2) != 0) begin
        vc = 1'($urandom_range(0, 1));
        d = ($urandom_range(0, 7) == 0) ? 64'h0 : {32'($urandom), 32'($urandom)};
        drive_write(vc, d);
      end else begin
        wr_en = 1'b0; data_in = 64'h0;
      end
      cycle();
      checks++;
      if (send !== exp_send)
        begin failures++; $display("FAIL b2b_send[%0d]: got %b want %b", n, send, exp_send); end
      else if (send) begin
        sb_pop(polarity, exp, none);
        if (none || data_out !== exp)
          begin failures++; $display("FAIL b2b_data[%0d]: got %h want %h", n, data_out, exp); end
      end else if (data_out !== 64'h0)
        begin failures++; $display("FAIL b2b_idle_data[%0d]: got %h want 0", n, data_out); end
      checks++;
      if (vc_full !== {q1.size() == 4, q0.size() == 4})
        begin failures++; $display("FAIL b2b_full[%0d]: got %b want %b", n, vc_full, {q1.size() == 4, q0.size() == 4}); end
    end
    wr_en = 1'b0; data_in = 64'h0;
`ifdef ROUTER_OUT_STATS_EN
    checks++;
    if (tx_count !== 16'(tx_model) || drop_count !== 16'(drop_model))
      begin failures++; $display("FAIL b2b_stats: tx=%0d drop=%0d want %0d/%0d", tx_count, drop_count, tx_model, drop_model); end
`endif
  endtask

  task automatic test_reset_midflight();
    logic [63:0] exp; bit none;
    ready_in = 1'b0; polarity = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_write(1'b0, 64'h21 + 64'(i)); cycle();
      drive_write(1'b1, 64'h31 + 64'(i)); cycle();
    end
    wr_en = 1'b0; data_in = 64'h0; ready_in = 1'b1;
    cycle();
    sb_pop(1'b0, exp, none);
    checks++;
    if (none || send !== 1'b1 || data_out !== exp || vc_full !== 2'b10)
      begin failures++; $display("FAIL pre_reset: send=%b data=%h full=%b want 1/%h/10", send, data_out, vc_full, exp); end
    reset = 1'b1;
    cycle();
    checks++;
    if (send !== 1'b0 || data_out !== 64'h0 || vc_full !== 2'b00)
      begin failures++; $display("FAIL mid_reset: send=%b data=%h full=%b want 0/0/00", send, data_out, vc_full); end
    reset = 1'b0;
    q0.delete(); q1.delete(); tx_model = 0; drop_model = 0;
    for (int i = 0; i < 6; i++) begin
      polarity = 1'(i % 2);
      cycle();
      checks++;
      if (send !== 1'b0 || data_out !== 64'h0)
        begin failures++; $display("FAIL stale[%0d]: send=%b data=%h want 0/0", i, send, data_out); end
    end
`ifdef ROUTER_OUT_STATS_EN
    checks++;
    if (tx_count !== 16'h0 || drop_count !== 16'h0)
      begin failures++; $display("FAIL stats_reset: tx=%0d drop=%0d want 0/0", tx_count, drop_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_vc0();
    test_vc1_polarity();
    test_full_drop();
    test_full_pop_write();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
